// File: rtl/uart_tx.sv
// uart_tx: drains a FWFT byte FIFO and serialises each word onto tx with a runtime bit-period divisor
module uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int DVSR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DVSR_WIDTH-1:0] dvsr,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  rd,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
  state_e                state_q, state_d;
  logic [DVSR_WIDTH-1:0] tick_q, tick_d, dvsr_q, dvsr_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d, rd_q, rd_d, busy_q, busy_d, done_q, done_d;
  logic                  last_tick;
  // next-state and registered-output values; the tick counter restarts on equality so dvsr=all-ones never wraps early
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    dvsr_d    = dvsr_q;
    tx_d      = tx_q;
    rd_d      = 1'b0;
    done_d    = 1'b0;
    last_tick = (tick_q == dvsr_q);
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          state_d = START;
          shift_d = r_data;
          dvsr_d  = dvsr;
          rd_d    = 1'b1;
          tx_d    = 1'b0;
          tick_d  = '0;
        end
      end
      START: begin
        tick_d = last_tick ? '0 : tick_q + 1'b1;
        if (last_tick) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        tick_d = last_tick ? '0 : tick_q + 1'b1;
        if (last_tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == BW'(DATA_WIDTH - 1)) begin
            state_d = STOP;
            bit_d   = '0;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
            tx_d  = shift_d[0];
          end
        end
      end
      STOP: begin
        tick_d = last_tick ? '0 : tick_q + 1'b1;
        if (last_tick) begin
          if (bit_q == BW'(STOP_BITS - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end
  // state and output registers; reset drops any in-flight byte and returns the line to idle-high
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      dvsr_q  <= '0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      dvsr_q  <= dvsr_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign tx      = tx_q;
  assign rd      = rd_q;
  assign busy    = busy_q;
  assign tx_done = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx framing, FIFO handshake, divisor latching and mid-frame reset
module tb_uart_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        reset_n = 1'b0;
  logic [15:0] dvsr_a = 16'd3, dvsr_b = 16'd1;
  logic [7:0]  mem_a [0:15];
  logic [7:0]  mem_b [0:15];
  int          wp_a = 0, rp_a = 0, wp_b = 0, rp_b = 0;
  logic        empty_a, empty_b, rd_a, rd_b, tx_a, tx_b, busy_a, busy_b, done_a, done_b;
  logic [7:0]  rdata_a, rdata_b;
  logic        sel = 1'b0;
  logic        tx_m, rd_m, busy_m, done_m;
  int          n_checks = 0, n_fail = 0;
  int          gap, t;

  assign empty_a = (wp_a == rp_a);
  assign empty_b = (wp_b == rp_b);
  assign rdata_a = mem_a[rp_a[3:0]];
  assign rdata_b = mem_b[rp_b[3:0]];
  assign tx_m    = sel ? tx_b   : tx_a;
  assign rd_m    = sel ? rd_b   : rd_a;
  assign busy_m  = sel ? busy_b : busy_a;
  assign done_m  = sel ? done_b : done_a;

  always @(posedge clk) if (rd_a) rp_a <= rp_a + 1;
  always @(posedge clk) if (rd_b) rp_b <= rp_b + 1;

  uart_tx #(.DATA_WIDTH(8), .STOP_BITS(1), .DVSR_WIDTH(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .dvsr(dvsr_a), .empty(empty_a), .r_data(rdata_a),
    .rd(rd_a), .tx(tx_a), .busy(busy_a), .tx_done(done_a));

  uart_tx #(.DATA_WIDTH(8), .STOP_BITS(2), .DVSR_WIDTH(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .dvsr(dvsr_b), .empty(empty_b), .r_data(rdata_b),
    .rd(rd_b), .tx(tx_b), .busy(busy_b), .tx_done(done_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_a(input logic [7:0] b);
    mem_a[wp_a[3:0]] = b;
    wp_a++;
  endtask

  task automatic push_b(input logic [7:0] b);
    mem_b[wp_b[3:0]] = b;
    wp_b++;
  endtask

  // waits (bounded) for the start bit, then checks every cycle of the frame up to the tx_done cycle
  task automatic check_frame(input string tag, input logic [7:0] b, input int p, input int stops, output int g);
    int   len;
    logic e_tx;
    len = (9 + stops) * p;
    g = 0;
    while (tx_m !== 1'b0 && g < 500) begin
      @(negedge clk);
      g++;
    end
    for (int c = 0; c <= len; c++) begin
      e_tx = (c < p) ? 1'b0 : (c < 9 * p) ? b[(c - p) / p] : 1'b1;
      check({tag, "_tx"},   32'(tx_m),   32'(e_tx));
      check({tag, "_rd"},   32'(rd_m),   32'(c == 0));
      check({tag, "_busy"}, 32'(busy_m), 32'(c < len));
      check({tag, "_done"}, 32'(done_m), 32'(c == len));
      if (c < len) @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx",   32'(tx_a),   32'd1);
    check("rst_rd",   32'(rd_a),   32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_txb",  32'(tx_b),   32'd1);
    check("rst_busyb",32'(busy_b), 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_tx",   32'(tx_a),   32'd1);
      check("idle_rd",   32'(rd_a),   32'd0);
      check("idle_busy", 32'(busy_a), 32'd0);
      check("idle_done", 32'(done_a), 32'd0);
    end
    sel = 1'b0;
    dvsr_a = 16'd3;
    push_a(8'hA5);
    check_frame("a5", 8'hA5, 4, 1, gap);
    check("a5_launch", 32'(gap), 32'd1);
    repeat (3) @(negedge clk);
    dvsr_a = 16'd0;
    push_a(8'h00);
    push_a(8'hFF);
    check_frame("b2b0", 8'h00, 1, 1, gap);
    check_frame("b2b1", 8'hFF, 1, 1, gap);
    check("b2b_gap", 32'(gap), 32'd1);
    repeat (3) @(negedge clk);
    dvsr_a = 16'd3;
    push_a(8'h5A);
    push_a(8'h96);
    fork
      check_frame("dv0", 8'h5A, 4, 1, gap);
      begin
        repeat (10) @(negedge clk);
        dvsr_a = 16'd7;
      end
    join
    check_frame("dv1", 8'h96, 8, 1, gap);
    repeat (2) @(negedge clk);
    sel = 1'b1;
    dvsr_b = 16'd1;
    push_b(8'h80);
    check_frame("sb2", 8'h80, 2, 2, gap);
    sel = 1'b0;
    repeat (2) @(negedge clk);
    dvsr_a = 16'd3;
    push_a(8'h3C);
    push_a(8'hC3);
    t = 0;
    while (tx_a !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("mr_start", 32'(tx_a), 32'd0);
    repeat (17) @(negedge clk);
    check("mr_bit3_tx",  32'(tx_a),   32'd1);
    check("mr_pre_busy", 32'(busy_a), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check("mr_tx",   32'(tx_a),   32'd1);
    check("mr_busy", 32'(busy_a), 32'd0);
    check("mr_rd",   32'(rd_a),   32'd0);
    check("mr_done", 32'(done_a), 32'd0);
    reset_n = 1'b1;
    check_frame("mr_next", 8'hC3, 4, 1, gap);
    check("mr_pops", 32'(rp_a), 32'd7);
    repeat (5) @(negedge clk);
    check("end_rd",   32'(rd_a),   32'd0);
    check("end_busy", 32'(busy_a), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter that drains the byte FIFO directly downstream of it. It watches the FIFO's empty flag and pops one word with a single-cycle rd pulse. It serialises the word onto a single tx line: 8N1-style framing, LSB first, configurable stop bits. Bit timing comes from an internal divider loaded from a runtime divisor input, so no external tick generator is needed.

Parameters:
DATA_WIDTH, 8, data bits per frame; equals the FIFO word width.
STOP_BITS, 1, number of stop bits per frame (1 or 2).
DVSR_WIDTH, 16, width of the bit-period divisor input.

Ports:
clk  input  1  system clock; all logic on rising edge
reset_n  input  1  synchronous, active-low reset
dvsr  input  DVSR_WIDTH  bit period minus one, in clk cycles; sampled at frame start
empty  input  1  FIFO empty flag
r_data  input  DATA_WIDTH  FIFO head word (valid whenever empty=0, first-word-fall-through)
rd  output  1  FIFO pop strobe, one cycle per frame
tx  output  1  serial line, idle high
busy  output  1  high while a frame is in progress (state != IDLE)
tx_done  output  1  one-cycle pulse when the last stop bit completes

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-low (reset_n), sampled on the rising clk edge.
- Reset values: state=IDLE, tx=1, rd=0, busy=0, tx_done=0, bit/tick counters=0.
- All outputs are registered. No combinational path from any input to any output.
- States are IDLE, START, DATA, STOP.
- Bit period P = dvsr+1 clk cycles. dvsr is latched when the frame starts; changes during a frame have no effect until the next frame.
- IDLE:
  - tx=1.
  - On an edge with empty=0: latch r_data into the shift register and latch dvsr.
  - On the same edge: rd<=1 for exactly one cycle, tx<=0, tick counter<=0, go to START.
  - With empty=1: remain in IDLE and keep rd=0.
- START: tx=0 for P cycles, then go to DATA with bit index 0.
- DATA:
  - tx = shift[0]; each bit lasts P cycles.
  - At the end of each period, shift right and increment the bit index.
  - After bit index DATA_WIDTH-1 completes, go to STOP.
- STOP:
  - tx=1 for STOP_BITS*P cycles.
  - Then go to IDLE with tx_done<=1 for one cycle.
- Frame length is (1+DATA_WIDTH+STOP_BITS)*P cycles, measured from the first cycle tx=0 to the cycle tx_done is high.
- Back-to-back frames: at least one IDLE cycle separates frames. The next start bit begins the cycle after tx_done when empty=0.
- rd fires only on the IDLE->START transition, so there is never a second pop within a frame. The FIFO pointer advances on the edge at the end of the rd cycle; by then the data is already captured.
- dvsr=0 is legal: one clk per bit.
- The tick counter is DVSR_WIDTH bits and compares for equality with the latched dvsr. It must not wrap prematurely at dvsr = all-ones.
- empty rising mid-frame: no effect on the current frame.
- Reset mid-frame: next edge forces all reset values (tx=1). The in-flight byte is discarded and is not re-read from the FIFO.

Test Plan:
- Single byte, DATA_WIDTH=8, STOP_BITS=1, dvsr=3, FIFO holds 0xA5 -> rd high for exactly 1 cycle. tx per 4-cycle slot is 0,1,0,1,0,0,1,0,1,1. tx_done pulses 40 cycles after tx first falls; busy high throughout.
- Empty FIFO, empty=1 held for 100 cycles -> rd=0, tx=1, busy=0, tx_done=0 throughout.
- Back-to-back 0x00 then 0xFF, dvsr=0 -> two rd pulses 11 cycles apart. tx is 0 for 9 cycles, then 1, then one idle high cycle, then 0 for 1 cycle and 1 for 9 cycles. Two tx_done pulses.
- STOP_BITS=2, dvsr=1, byte 0x80 -> stop interval is tx=1 for 4 cycles; tx_done 22 cycles after start.
- dvsr changed from 3 to 7 mid-frame -> current frame keeps 4-cycle bits; the next frame uses 8-cycle bits.
- reset_n low for 1 cycle during DATA bit 3 -> next edge gives tx=1, busy=0, rd=0. After release, a new frame starts with the next FIFO word; no re-pop of the aborted byte.
